// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone burst-write master draining a first-word-fall-through FIFO into a circular buffer.
// Optional level interrupt built when WB_STREAM_WRITER_CTRL_IRQ_EN is defined.
module wb_stream_writer_ctrl #(
  parameter int WB_AW         = 32,
  parameter int WB_DW         = 32,
  parameter int MAX_BURST_LEN = 8,
  parameter int FIFO_AW       = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable_i,
  input  logic [WB_AW-1:0]     start_adr_i,
  input  logic [WB_AW-1:0]     buf_size_i,
  input  logic [WB_DW-1:0]     fifo_d_i,
  input  logic [FIFO_AW:0]     fifo_cnt_i,
  output logic                 fifo_rd_o,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 irq_o,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: the FIFO head is valid while fifo_cnt_i>0 and is consumed by a
  // fifo_rd_o pulse; a bus beat is offered while cyc&stb and completes in any
  // cycle with wbm_ack_i (and no wbm_err_i), which is exactly when we pop.

  localparam int BPB = WB_DW / 8;
  localparam int BW  = $clog2(MAX_BURST_LEN + 1);
  localparam int CW  = (FIFO_AW + 1 > BW) ? FIFO_AW + 1 : BW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WB_AW-1:0] base_q, base_d;
  logic [WB_AW-1:0] size_q, size_d;
  logic [WB_AW-1:0] adr_q, adr_d;
  logic [WB_AW-1:0] rem_q, rem_d;
  logic [BW-1:0]    blen_q, blen_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [BW-1:0]    blen_calc;
  logic             fifo_ready;
  logic             in_burst;
  logic             last_beat;

  // Clip the burst to what is left before the buffer end so it never wraps mid-burst.
  always_comb begin
    blen_calc = BW'(MAX_BURST_LEN);
    if (rem_q < WB_AW'(MAX_BURST_LEN)) blen_calc = BW'(rem_q);
  end

  assign fifo_ready = (CW'(fifo_cnt_i) >= CW'(blen_calc));
  assign in_burst   = (state_q == S_BURST);
  assign last_beat  = (beat_q == (blen_q - BW'(1)));

  assign wbm_cyc_o   = in_burst;
  assign wbm_stb_o   = in_burst;
  assign wbm_we_o    = in_burst;
  assign wbm_sel_o   = {BPB{in_burst}};
  assign wbm_cti_o   = in_burst ? (last_beat ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o   = 2'b00;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = fifo_d_i;
  assign fifo_rd_o   = in_burst & wbm_ack_i & ~wbm_err_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    size_d  = size_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    blen_d  = blen_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        // A latched error blocks restart until software drops enable_i.
        if (!enable_i) begin
          err_d = 1'b0;
        end else if ((buf_size_i != '0) && !err_q) begin
          base_d  = start_adr_i;
          size_d  = buf_size_i;
          adr_d   = start_adr_i;
          rem_d   = buf_size_i;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (fifo_ready) begin
          blen_d  = blen_calc;
          beat_d  = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (wbm_err_i) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (wbm_ack_i) begin
          beat_d = beat_q + BW'(1);
          if (rem_q == WB_AW'(1)) begin
            adr_d  = base_q;
            rem_d  = size_q;
            done_d = 1'b1;
          end else begin
            adr_d = adr_q + WB_AW'(BPB);
            rem_d = rem_q - WB_AW'(1);
          end
          if (last_beat) state_d = enable_i ? S_WAIT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      size_q  <= '0;
      adr_q   <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      blen_q  <= blen_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef WB_STREAM_WRITER_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else if (done_d || (in_burst && wbm_err_i)) begin
      irq_q <= 1'b1;
    end else if ((state_q == S_IDLE) && !enable_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Directed bench for wb_stream_writer_ctrl: bursts, wrap, FIFO starvation, bus error,
// enable drop mid-burst, reset mid-burst and zero-size buffer.
`timescale 1ns/1ps
module tb_wb_stream_writer_ctrl;

`ifdef WB_STREAM_WRITER_CTRL_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] start_adr;
  logic [31:0] buf_size;
  logic [31:0] fifo_d;
  logic [4:0]  fifo_cnt;
  logic        fifo_rd;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err;
  logic        busy, done, err_o, irq;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  int p0;

  wb_stream_writer_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable),
    .start_adr_i(start_adr), .buf_size_i(buf_size),
    .fifo_d_i(fifo_d), .fifo_cnt_i(fifo_cnt), .fifo_rd_o(fifo_rd),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_ack_i(ack), .wbm_err_i(err),
    .busy_o(busy), .done_o(done), .err_o(err_o), .irq_o(irq),
    .dbg_state_o(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_rd) pop_cnt <= pop_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input string tag, input int budget);
    int i;
    i = 0;
    while (!cyc && i < budget) begin
      step();
      i++;
    end
    chk(tag, {31'd0, cyc}, 32'd1);
  endtask

  // Acks every beat from the current cycle on; err_beat injects err (with ack) on that beat.
  task automatic do_burst(input string tag, input logic [31:0] adr0, input int len,
                          input int err_beat, input int drop_beat,
                          input logic exp_done, input logic [4:0] cnt_after);
    for (int b = 0; b < len; b++) begin
      if (b > 0) step();
      ack    = 1'b1;
      err    = (b == err_beat);
      fifo_d = 32'hD000_0000 + adr0 + b;
      if (b == drop_beat) enable = 1'b0;
      #1;
      chk({tag, "_cyc"}, {31'd0, cyc}, 32'd1);
      chk({tag, "_adr"}, adr, adr0 + 32'(4 * b));
      chk({tag, "_cti"}, {29'd0, cti}, (b == len - 1) ? 32'd7 : 32'd2);
      chk({tag, "_rd"}, {31'd0, fifo_rd}, (b == err_beat) ? 32'd0 : 32'd1);
      chk({tag, "_dat"}, dat, 32'hD000_0000 + adr0 + b);
      chk({tag, "_ctl"}, {24'd0, sel, we, stb, bte}, {24'd0, 4'hF, 1'b1, 1'b1, 2'b00});
      chk({tag, "_done_mid"}, {31'd0, done}, 32'd0);
      if (b == err_beat) break;
    end
    step();
    ack      = 1'b0;
    err      = 1'b0;
    fifo_cnt = cnt_after;
    #1;
    chk({tag, "_cyc_end"}, {31'd0, cyc}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; start_adr = '0; buf_size = '0;
    fifo_d = '0; fifo_cnt = '0; ack = 1'b0; err = 1'b0;
    repeat (3) step();
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_ctl", {24'd0, sel, we, stb, cti, fifo_rd}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_status", {28'd0, busy, done, err_o, irq}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    rst = 1'b0;
    step();

    // 1: size 16 -> two 8-beat bursts, done, address back at base
    start_adr = 32'h1000; buf_size = 32'd16; fifo_cnt = 5'd16; enable = 1'b1;
    p0 = pop_cnt;
    step();
    chk("t1_wait", {30'd0, state}, 32'd1);
    wait_cyc("t1_start_a", 4);
    do_burst("t1a", 32'h1000, 8, -1, -1, 1'b0, 5'd16);
    wait_cyc("t1_start_b", 4);
    do_burst("t1b", 32'h1020, 8, -1, -1, 1'b1, 5'd0);
    chk("t1_adr_base", adr, 32'h1000);
    chk("t1_state", {30'd0, state}, 32'd1);
    chk("t1_irq", {31'd0, irq}, {31'd0, IRQ});
    chk("t1_pops", 32'(pop_cnt - p0), 32'd16);
    step();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    enable = 1'b0;
    step();
    chk("t1_idle", {30'd0, state, busy}, 32'd0);
    step();
    chk("t1_irq_clr", {31'd0, irq}, 32'd0);

    // 2: size 10 -> bursts of 8 then 2
    start_adr = 32'h2000; buf_size = 32'd10; fifo_cnt = 5'd10; enable = 1'b1;
    p0 = pop_cnt;
    wait_cyc("t2_start_a", 5);
    do_burst("t2a", 32'h2000, 8, -1, -1, 1'b0, 5'd2);
    wait_cyc("t2_start_b", 3);
    do_burst("t2b", 32'h2020, 2, -1, -1, 1'b1, 5'd0);
    chk("t2_adr_base", adr, 32'h2000);
    chk("t2_pops", 32'(pop_cnt - p0), 32'd10);
    enable = 1'b0;
    step();
    step();
    chk("t2_idle", {30'd0, state}, 32'd0);

    // 3: FIFO short of a full burst -> hold in WAIT, start 1 cycle after fill
    start_adr = 32'h3000; buf_size = 32'd16; fifo_cnt = 5'd5; enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", {29'd0, state, cyc}, {29'd0, 2'd1, 1'b0});
      step();
    end
    fifo_cnt = 5'd8;
    step();
    chk("t3_latency", {31'd0, cyc}, 32'd1);
    do_burst("t3", 32'h3000, 8, -1, -1, 1'b0, 5'd0);
    enable = 1'b0;
    step();
    chk("t3_idle", {30'd0, state}, 32'd0);

    // 4: bus error on beat 3 (ack also high) -> 2 pops, IDLE, sticky err
    start_adr = 32'h4000; buf_size = 32'd16; fifo_cnt = 5'd16; enable = 1'b1;
    p0 = pop_cnt;
    wait_cyc("t4_start", 5);
    do_burst("t4", 32'h4000, 8, 2, -1, 1'b0, 5'd16);
    chk("t4_state", {30'd0, state}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_err", {31'd0, err_o}, 32'd1);
    chk("t4_irq", {31'd0, irq}, {31'd0, IRQ});
    chk("t4_pops", 32'(pop_cnt - p0), 32'd2);
    repeat (3) step();
    chk("t4_lockout", {29'd0, state, cyc}, 32'd0);
    enable = 1'b0;
    step();
    chk("t4_err_clr", {30'd0, err_o, irq}, 32'd0);
    enable = 1'b1;
    step();
    chk("t4_restart", {30'd0, state}, 32'd1);
    enable = 1'b0;
    step();
    step();

    // 5: enable dropped mid-burst -> burst finishes, then IDLE
    start_adr = 32'h5000; buf_size = 32'd16; fifo_cnt = 5'd16; enable = 1'b1;
    wait_cyc("t5_start", 5);
    do_burst("t5", 32'h5000, 8, -1, 3, 1'b0, 5'd16);
    chk("t5_idle", {30'd0, state, busy}, 32'd0);
    step();
    chk("t5_stay", {31'd0, cyc}, 32'd0);

    // 6: reset mid-burst, then zero-size buffer never starts
    start_adr = 32'h6000; buf_size = 32'd16; fifo_cnt = 5'd16; enable = 1'b1;
    wait_cyc("t6_start", 5);
    ack = 1'b1;
    #1;
    chk("t6_rd", {31'd0, fifo_rd}, 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_bus", {23'd0, cyc, stb, we, sel, cti, fifo_rd}, 32'd0);
    chk("t6_rst_adr", adr, 32'd0);
    chk("t6_rst_status", {26'd0, state, busy, done, err_o, irq}, 32'd0);
    rst = 1'b0; ack = 1'b0; enable = 1'b0;
    step();
    start_adr = 32'h7000; buf_size = 32'd0; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t6_zero_size", {30'd0, cyc, busy}, 32'd0);
    end
    enable = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
